// File: rtl/bsg_nonsynth_wormhole_vcache_concentrator.sv
// Wormhole concentrator between the vcache DMA links and the test memory.
// Forward packets from num_in_p links are arbitrated round-robin per packet onto
// one link; fill packets coming back are steered to the link named by header cid.
// Pure passthrough: no flit storage, only grant/index/count state per direction.
module bsg_nonsynth_wormhole_vcache_concentrator
  #(parameter int num_in_p        = 2
   ,parameter int wh_flit_width_p = 32
   ,parameter int wh_cord_width_p = 7
   ,parameter int wh_len_width_p  = 4
   ,parameter int wh_cid_width_p  = 2
   ,parameter bit debug_p         = 1'b0
   )
   (input  logic                                            clk_i
   ,input  logic                                            reset_i
   ,input  logic [num_in_p-1:0][wh_flit_width_p+2-1:0]      links_i
   ,output logic [num_in_p-1:0][wh_flit_width_p+2-1:0]      links_o
   ,input  logic [wh_flit_width_p+2-1:0]                    conc_link_i
   ,output logic [wh_flit_width_p+2-1:0]                    conc_link_o
   );

   // Link layout is {v, data, ready_and_rev}; header is the bsg_cache wh header flit,
   // packed from the LSB as cord, len, cid, src_cord, src_cid, opcode.
   localparam int link_w_lp     = wh_flit_width_p + 2;
   localparam int lg_lp         = $clog2(num_in_p);
   localparam int len_lo_lp     = wh_cord_width_p;
   localparam int cid_lo_lp     = len_lo_lp + wh_len_width_p;
   localparam int src_cid_lo_lp = cid_lo_lp + wh_cid_width_p + wh_cord_width_p;

   typedef enum logic [1:0] {e_reset, e_idle, e_busy} state_e;

   state_e                     r_fwd_state, r_ret_state;
   logic [lg_lp-1:0]           r_rr_ptr, r_fwd_grant, r_ret_idx;
   logic [wh_len_width_p-1:0]  r_fwd_cnt, r_ret_cnt;

   logic [num_in_p-1:0]                       w_in_v, w_in_ready;
   logic [num_in_p-1:0][wh_flit_width_p-1:0]  w_in_data;
   logic                                      w_conc_v, w_conc_ready;
   logic [wh_flit_width_p-1:0]                w_conc_data;
   logic                                      w_any_v;
   logic [lg_lp-1:0]                          w_rr_idx, w_rr_pick, w_fwd_src, w_ret_dst;
   logic                                      w_fwd_active, w_ret_active;
   logic                                      w_fwd_v, w_ret_ready, w_fwd_hs, w_ret_hs;
   logic [wh_flit_width_p-1:0]                w_fwd_data;

   // Split the packed links into their v / data / ready fields
   always_comb begin
      for (int k = 0; k < num_in_p; k++) begin
         w_in_v[k]     = links_i[k][link_w_lp-1];
         w_in_data[k]  = links_i[k][link_w_lp-2:1];
         w_in_ready[k] = links_i[k][0];
      end
      w_conc_v     = conc_link_i[link_w_lp-1];
      w_conc_data  = conc_link_i[link_w_lp-2:1];
      w_conc_ready = conc_link_i[0];
   end

   // Round-robin pick: first valid input at or after the pointer, independent of ready
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      w_any_v   = 1'b0;
      w_rr_pick = r_rr_ptr;
      w_rr_idx  = r_rr_ptr;
      for (int i = num_in_p-1; i >= 0; i--) begin
         w_rr_idx = r_rr_ptr + lg_lp'(i);
         if (w_in_v[w_rr_idx]) begin
            w_any_v   = 1'b1;
            w_rr_pick = w_rr_idx;
         end
      end
   end

   // Path selection; all v/ready outputs are forced low during reset and the RESET cycle
   always_comb begin
      w_fwd_src    = (r_fwd_state == e_busy) ? r_fwd_grant : w_rr_pick;
      w_fwd_active = !reset_i && (((r_fwd_state == e_idle) && w_any_v) || (r_fwd_state == e_busy));
      w_fwd_v      = w_fwd_active && w_in_v[w_fwd_src];
      w_fwd_data   = w_in_data[w_fwd_src];
      w_ret_dst    = (r_ret_state == e_busy) ? r_ret_idx : w_conc_data[cid_lo_lp +: lg_lp];
      w_ret_active = !reset_i && ((r_ret_state == e_idle) || (r_ret_state == e_busy));
      w_ret_ready  = w_ret_active && w_in_ready[w_ret_dst];
      w_fwd_hs     = w_fwd_v && w_conc_ready;
      w_ret_hs     = w_conc_v && w_ret_ready;
      for (int k = 0; k < num_in_p; k++) begin
         links_o[k] = {w_ret_active && (w_ret_dst == lg_lp'(k)) && w_conc_v,
                       w_conc_data,
                       w_fwd_active && (w_fwd_src == lg_lp'(k)) && w_conc_ready};
      end
      conc_link_o = {w_fwd_v, w_fwd_data, w_ret_ready};
   end

   // Forward FSM: grant held for a whole packet, pointer advances past the winner at its end
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (reset_i) begin
         r_fwd_state <= e_reset;
         r_rr_ptr    <= '0;
         r_fwd_grant <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         unique case (r_fwd_state)
            e_reset: r_fwd_state <= e_idle;
            e_idle: if (w_fwd_hs) begin
               r_fwd_grant <= w_rr_pick;
               r_fwd_cnt   <= w_fwd_data[len_lo_lp +: wh_len_width_p];
               if (w_fwd_data[len_lo_lp +: wh_len_width_p] == '0)
                  r_rr_ptr <= w_rr_pick + 1'b1;
               else
                  r_fwd_state <= e_busy;
            end
            e_busy: if (w_fwd_hs) begin
               r_fwd_cnt <= r_fwd_cnt - 1'b1;
               if (r_fwd_cnt == wh_len_width_p'(1)) begin
                  r_fwd_state <= e_idle;
                  r_rr_ptr    <= r_fwd_grant + 1'b1;
               end
            end
            default: r_fwd_state <= e_reset;
         endcase
      end
   end

   // Return FSM: destination latched from header cid, held until the last fill flit
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_ret_state <= e_reset;
         r_ret_idx   <= '0;
         r_ret_cnt   <= '0;
      end else begin
         unique case (r_ret_state)
            e_reset: r_ret_state <= e_idle;
            e_idle: if (w_ret_hs) begin
               r_ret_idx <= w_ret_dst;
               r_ret_cnt <= w_conc_data[len_lo_lp +: wh_len_width_p];
               if (w_conc_data[len_lo_lp +: wh_len_width_p] != '0)
                  r_ret_state <= e_busy;
            end
            e_busy: if (w_ret_hs) begin
               r_ret_cnt <= r_ret_cnt - 1'b1;
               if (r_ret_cnt == wh_len_width_p'(1))
                  r_ret_state <= e_idle;
            end
            default: r_ret_state <= e_reset;
         endcase
      end
   end

   // A forward header must carry its own link index in the low bits of src_cid
   assert property (@(posedge clk_i) disable iff (reset_i)
      ((r_fwd_state == e_idle) && w_fwd_hs) |-> (w_fwd_data[src_cid_lo_lp +: lg_lp] == w_rr_pick))
      else $error("forward header src_cid does not match input link index");

   if (wh_cid_width_p > lg_lp) begin : g_cid_range
      // A wider cid space must never name a link that does not exist
      assert property (@(posedge clk_i) disable iff (reset_i)
         ((r_ret_state == e_idle) && w_conc_v) |->
            (w_conc_data[cid_lo_lp +: wh_cid_width_p] < wh_cid_width_p'(num_in_p)))
         else $error("return header cid out of range");
   end

   if (debug_p) begin : g_debug
      // Header handshakes in both directions show up in the coverage report
      cover property (@(posedge clk_i) disable iff (reset_i) (r_fwd_state == e_idle) && w_fwd_hs);
      cover property (@(posedge clk_i) disable iff (reset_i) (r_ret_state == e_idle) && w_ret_hs);
   end

endmodule

// File: tb/tb_bsg_nonsynth_wormhole_vcache_concentrator.sv
// Self-checking bench: randomized and directed traffic on both directions, compared
// every cycle against a packet-level model (owner / flits-left / rr pointer).
`timescale 1ns/1ps
module tb_bsg_nonsynth_wormhole_vcache_concentrator;
  localparam int N          = 2;
  localparam int FW         = 32;
  localparam int CORDW      = 7;
  localparam int LENW       = 4;
  localparam int CIDW       = 2;
  localparam int LW         = FW + 2;
  localparam int LEN_LO     = CORDW;
  localparam int CID_LO     = LEN_LO + LENW;
  localparam int SRC_CID_LO = CID_LO + CIDW + CORDW;

  typedef logic [FW-1:0] flit_t;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic [N-1:0][LW-1:0]  links_i, links_o;
  logic [LW-1:0]         conc_link_i, conc_link_o;

  bsg_nonsynth_wormhole_vcache_concentrator #(
    .num_in_p(N), .wh_flit_width_p(FW), .wh_cord_width_p(CORDW),
    .wh_len_width_p(LENW), .wh_cid_width_p(CIDW), .debug_p(1'b0)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .links_i(links_i), .links_o(links_o),
    .conc_link_i(conc_link_i), .conc_link_o(conc_link_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  flit_t fq[N][$];          // forward flits waiting on each input
  flit_t rq[$];             // fill flits waiting at the test mem side
  flit_t fwd_log[$];        // flits accepted on conc_link_o
  flit_t ret_log[N][$];     // flits accepted on each links_o
  flit_t pushed[$];         // flits pushed by the current directed test, in order
  int    gap[N];
  int    hold_rdy[N];
  int    bubble_pct   = 0;
  int    conc_rdy_mode = 0;  // 0 always, 1 toggle, 2 random
  bit    link_rdy_rand = 0;
  bit    tog = 0;
  int    stall_cnt = 0;
  logic [63:0] obs_ctl;
  int    pushed_f_total = 0, pushed_r_total = 0;

  // ---------------- reference model state ----------------
  int m_rst = 1, f_owner = -1, f_left = 0, f_ptr = 0, r_owner = -1, r_left = 0;

  function automatic bit    in_v(int k); return links_i[k][LW-1]; endfunction
  function automatic flit_t in_d(int k); return links_i[k][LW-2:1]; endfunction
  function automatic bit    in_r(int k); return links_i[k][0]; endfunction

  function automatic flit_t make_hdr(int len, int cid, int src_cid, int tag);
    flit_t h = '0;
    h[CORDW-1:0]           = tag[CORDW-1:0];
    h[LEN_LO +: LENW]      = len[LENW-1:0];
    h[CID_LO +: CIDW]      = cid[CIDW-1:0];
    h[SRC_CID_LO +: CIDW]  = src_cid[CIDW-1:0];
    h[FW-1:24]             = tag[7:0];
    return h;
  endfunction

  task automatic push_fwd(input int k, input int len, input int tag);
    flit_t f;
    f = make_hdr(len, k, k, tag);
    fq[k].push_back(f); pushed.push_back(f);
    for (int j = 1; j <= len; j++) begin
      f = {k[3:0], tag[7:0], j[19:0]};
      fq[k].push_back(f); pushed.push_back(f);
    end
    pushed_f_total += len + 1;
  endtask

  task automatic push_fill(input int cid, input int len, input int tag);
    flit_t f;
    f = make_hdr(len, cid, 0, tag);
    rq.push_back(f); pushed.push_back(f);
    for (int j = 1; j <= len; j++) begin
      f = {4'hf, tag[7:0], j[19:0]};
      rq.push_back(f); pushed.push_back(f);
    end
    pushed_r_total += len + 1;
  endtask

  task automatic drive();
    bit v, r;
    flit_t cd;
    for (int k = 0; k < N; k++) begin
      if (gap[k] > 0) begin gap[k]--; v = 0; end
      else v = (fq[k].size() > 0) && ($urandom_range(99) >= bubble_pct);
      links_i[k][LW-1]   = v;
      links_i[k][LW-2:1] = v ? fq[k][0] : flit_t'($urandom);
      if (hold_rdy[k] > 0) begin hold_rdy[k]--; r = 0; end
      else r = link_rdy_rand ? 1'($urandom_range(1)) : 1'b1;
      links_i[k][0] = r;
    end
    v = (rq.size() > 0) && ($urandom_range(99) >= bubble_pct);
    cd = flit_t'($urandom);
    cd[CID_LO +: CIDW] = 2'($urandom_range(N-1));
    conc_link_i[LW-1]   = v;
    conc_link_i[LW-2:1] = v ? rq[0] : cd;
    tog = ~tog;
    case (conc_rdy_mode)
      0: conc_link_i[0] = 1'b1;
      1: conc_link_i[0] = tog;
      default: conc_link_i[0] = 1'($urandom_range(1));
    endcase
  endtask

  // One clock: compare outputs to the model at negedge, advance model, then drive new inputs.
  task automatic step();
    bit blank, e_cv, e_rv, fhs, rhs;
    bit pop_f[N];
    bit pop_r;
    int cand, tgt, len;
    flit_t cd, hd;
    @(negedge clk_i);
    blank = reset_i || (m_rst != 0);
    cand = f_owner;
    if (cand < 0)
      for (int i = 0; i < N; i++) begin
        int k;
        k = (f_ptr + i) % N;
        if (cand < 0 && in_v(k)) cand = k;
      end
    cd  = conc_link_i[LW-2:1];
    tgt = (r_owner >= 0) ? r_owner : int'(cd[CID_LO +: CIDW]) % N;

    e_cv = !blank && cand >= 0 && in_v(cand >= 0 ? cand : 0);
    check("conc_v", conc_link_o[LW-1], e_cv);
    if (e_cv) check("conc_data", conc_link_o[LW-2:1], in_d(cand));
    for (int k = 0; k < N; k++)
      check($sformatf("fwd_ready%0d", k), links_o[k][0], !blank && cand == k && conc_link_i[0]);
    for (int k = 0; k < N; k++) begin
      e_rv = !blank && k == tgt && conc_link_i[LW-1];
      check($sformatf("ret_v%0d", k), links_o[k][LW-1], e_rv);
      if (e_rv) check($sformatf("ret_data%0d", k), links_o[k][LW-2:1], cd);
    end
    check("ret_ready", conc_link_o[0], !blank && in_r(tgt));
    fhs = e_cv && conc_link_i[0];
    rhs = !blank && conc_link_i[LW-1] && in_r(tgt);

    // observed traffic, used by the driver and the directed pins
    obs_ctl = {62'b0, conc_link_o[LW-1], conc_link_o[0]};
    for (int k = 0; k < N; k++) begin
      obs_ctl = {obs_ctl[61:0], links_o[k][LW-1], links_o[k][0]};
      pop_f[k] = in_v(k) && links_o[k][0];
      if (links_o[k][LW-1] && in_r(k)) ret_log[k].push_back(links_o[k][LW-2:1]);
    end
    pop_r = conc_link_i[LW-1] && conc_link_o[0];
    if (conc_link_o[LW-1] && conc_link_i[0]) fwd_log.push_back(conc_link_o[LW-2:1]);
    if (!blank && conc_link_i[LW-1] && !conc_link_o[0]) stall_cnt++;

    // model advance
    if (reset_i) begin
      m_rst = 1; f_owner = -1; f_left = 0; f_ptr = 0; r_owner = -1; r_left = 0;
    end else if (m_rst != 0) begin
      m_rst = 0;
    end else begin
      if (fhs) begin
        if (f_owner < 0) begin
          hd = in_d(cand);
          len = int'(hd[LEN_LO +: LENW]);
          if (len == 0) f_ptr = (cand + 1) % N;
          else begin f_owner = cand; f_left = len; end
        end else begin
          f_left--;
          if (f_left == 0) begin f_ptr = (f_owner + 1) % N; f_owner = -1; end
        end
      end
      if (rhs) begin
        if (r_owner < 0) begin
          len = int'(cd[LEN_LO +: LENW]);
          if (len != 0) begin r_owner = tgt; r_left = len; end
        end else begin
          r_left--;
          if (r_left == 0) r_owner = -1;
        end
      end
    end

    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++) if (pop_f[k] && fq[k].size() > 0) void'(fq[k].pop_front());
    if (pop_r && rq.size() > 0) void'(rq.pop_front());
    drive();
  endtask

  function automatic bit busy();
    bit b = (rq.size() > 0);
    for (int k = 0; k < N; k++) if (fq[k].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin step(); n++; end
    check("drain_done", !busy(), 1);
    step(); step();
  endtask

  task automatic clear_logs();
    fwd_log.delete(); pushed.delete(); stall_cnt = 0;
    for (int k = 0; k < N; k++) ret_log[k].delete();
  endtask

  // Reset for one cycle; outputs must be quiet in that cycle and the RESET cycle after.
  task automatic do_reset(input bit hdr_on_in0);
    reset_i = 1'b1;
    rq.delete();
    for (int k = 0; k < N; k++) begin fq[k].delete(); gap[k] = 0; hold_rdy[k] = 0; end
    bubble_pct = 0; conc_rdy_mode = 0; link_rdy_rand = 0;
    clear_logs();
    if (hdr_on_in0) push_fwd(0, 0, 8'h66);
    drive();
    step();
    check("rst_quiet", obs_ctl, 64'd0);
    reset_i = 1'b0;
    step();
    check("reset_cycle_quiet", obs_ctl, 64'd0);
  endtask

  task automatic wait_fwd_log(input int n, input int maxc);
    int c = 0;
    while (fwd_log.size() < n && c < maxc) begin step(); c++; end
    check("fwd_log_reached", fwd_log.size() >= n, 1);
  endtask

  initial begin
    reset_i = 1'b1;
    links_i = '0;
    conc_link_i = '0;
    for (int k = 0; k < N; k++) begin gap[k] = 0; hold_rdy[k] = 0; end

    // 1: read header len=1 plus address 0x100 on In0 alone
    do_reset(0);
    fq[0].push_back(make_hdr(1, 0, 0, 8'h05));
    fq[0].push_back(32'h0000_0100);
    drain(50);
    check("t1_size", fwd_log.size(), 2);
    check("t1_hdr", fwd_log[0], 32'h0500_0085);
    check("t1_addr", fwd_log[1], 32'h0000_0100);
    // pointer now at 1: with both waiting, In1 goes first
    push_fwd(0, 0, 8'h10);
    push_fwd(1, 0, 8'h11);
    drain(50);
    check("t1_ptr_first", fwd_log[2][SRC_CID_LO +: CIDW], 1);
    check("t1_ptr_second", fwd_log[3][SRC_CID_LO +: CIDW], 0);

    // 2: both inputs saturated with 9-flit evicts; packets alternate, never interleave
    do_reset(0);
    for (int p = 0; p < 2; p++) begin push_fwd(0, 8, 8'h20 + p); push_fwd(1, 8, 8'h30 + p); end
    drain(200);
    check("t2_size", fwd_log.size(), 36);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("t2_hdr_src%0d", p), fwd_log[p*9][SRC_CID_LO +: CIDW], p % 2);
      for (int j = 1; j < 9; j++) begin
        check($sformatf("t2_data_src%0d_%0d", p, j), fwd_log[p*9+j][31:28], p % 2);
        check($sformatf("t2_data_idx%0d_%0d", p, j), fwd_log[p*9+j][19:0], j);
      end
    end

    // 3: toggling ready and a 3-cycle bubble on In1; grant stays on In1
    do_reset(0);
    conc_rdy_mode = 1;
    push_fwd(1, 4, 8'h41);
    wait_fwd_log(1, 20);
    push_fwd(0, 2, 8'h40);
    step();
    gap[1] = 3;
    drain(200);
    check("t3_size", fwd_log.size(), 8);
    for (int j = 0; j < 8; j++)
      check($sformatf("t3_flit%0d", j), fwd_log[j], pushed[j]);

    // 4: fill cid=1 len=4; link1 backpressure stalls the test mem for exactly 2 cycles
    do_reset(0);
    push_fill(1, 4, 8'h50);
    step(); step();
    hold_rdy[1] = 2;
    drain(100);
    check("t4_link0_empty", ret_log[0].size(), 0);
    check("t4_link1_size", ret_log[1].size(), 5);
    for (int j = 0; j < 5; j++) check($sformatf("t4_flit%0d", j), ret_log[1][j], pushed[j]);
    check("t4_stalls", stall_cnt, 2);

    // 5: forward on In1 and fill to link1 at the same time, random backpressure
    do_reset(0);
    link_rdy_rand = 1; conc_rdy_mode = 2;
    push_fwd(1, 3, 8'h61);
    push_fill(1, 3, 8'h62);
    drain(200);
    check("t5_fwd_size", fwd_log.size(), 4);
    check("t5_ret_size", ret_log[1].size(), 4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t5_fwd%0d", j), fwd_log[j], pushed[j]);
      check($sformatf("t5_ret%0d", j), ret_log[1][j], pushed[4+j]);
    end

    // 6: reset mid-packet, then a fresh header on In0 is accepted
    do_reset(0);
    push_fwd(0, 5, 8'h70);
    wait_fwd_log(3, 20);
    do_reset(1);
    drain(50);
    check("t6_size", fwd_log.size(), 1);
    check("t6_hdr", fwd_log[0], make_hdr(0, 0, 0, 8'h66));

    // random traffic in both directions
    do_reset(0);
    bubble_pct = 20; conc_rdy_mode = 2; link_rdy_rand = 1;
    pushed_f_total = 0; pushed_r_total = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++)
        if (fq[k].size() == 0 && $urandom_range(2) == 0)
          push_fwd(k, $urandom_range(6), $urandom_range(255));
      if (rq.size() == 0 && $urandom_range(2) == 0)
        push_fill($urandom_range(N-1), $urandom_range(6), $urandom_range(255));
      step();
    end
    drain(500);
    check("rand_fwd_count", fwd_log.size(), pushed_f_total);
    check("rand_ret_count", ret_log[0].size() + ret_log[1].size(), pushed_r_total);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
